// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int WORD_W   = 16;
   localparam int WAIT_W   = 3;
   localparam int STARVE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_e;

   typedef logic [1:0] grant_t;

   localparam grant_t GRANT_NONE = 2'd0;
   localparam grant_t GRANT_CPU  = 2'd1;
   localparam grant_t GRANT_DMA  = 2'd2;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable wait-state down-counter; tc is high while the count sits at zero.
module mem_wait_timer
   import mem_arb_pkg::*;
(
   input  logic              clk_sys,
   input  logic              rst_b,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              dec,
   output logic              tc
);

   logic [WAIT_W-1:0] count_q, count_d;

   assign tc = (count_q == '0);

   // Holds at zero rather than wrapping.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && !tc) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/DMA single-port memory arbiter with wait states.
// Optional DMA starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
//
// state     | meaning
// ST_IDLE   | no owner; arbitrate among pending requests
// ST_ACCESS | memory enabled for WAIT_STATES+1 cycles for the granted port
// ST_DONE   | one-cycle Ready pulse to the granted port
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WAIT_STATES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              CpuReq,
   input  logic              CpuWE,
   input  logic [WORD_W-1:0] CpuAddr,
   input  logic [WORD_W-1:0] CpuWData,
   output logic [WORD_W-1:0] CpuRData,
   output logic              CpuReady,
   input  logic              DmaReq,
   input  logic              DmaWE,
   input  logic [WORD_W-1:0] DmaAddr,
   input  logic [WORD_W-1:0] DmaWData,
   output logic [WORD_W-1:0] DmaRData,
   output logic              DmaReady,
   output logic              MemEn,
   output logic              MemWE,
   output logic [WORD_W-1:0] MemAddr,
   output logic [WORD_W-1:0] MemWData,
   input  logic [WORD_W-1:0] MemRData,
   output logic [1:0]        Grant
);

   if (WAIT_STATES > 7) begin : g_bad_wait
      $error("WAIT_STATES must be 0..7");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
      $error("STARVE_LIMIT must be 1..15");
   end

   arb_state_e        state_q, state_d;
   grant_t            grant_q, grant_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [WORD_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              tmr_dec, tmr_tc;
   logic              cpu_win, dma_win, dma_force;

   assign cpu_win = (state_q == ST_IDLE) && CpuReq && !(DmaReq && dma_force);
   assign dma_win = (state_q == ST_IDLE) && DmaReq && !cpu_win;
   assign tmr_dec = (state_q == ST_ACCESS);

   mem_wait_timer u_wait_timer (
      .clk_sys  (CLK),
      .rst_b    (Reset),
      .load     (cpu_win || dma_win),
      .load_val (WAIT_W'(WAIT_STATES)),
      .dec      (tmr_dec),
      .tc       (tmr_tc)
   );

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [STARVE_W-1:0] starve_q, starve_d;

   assign dma_force = (starve_q == STARVE_W'(STARVE_LIMIT));

   // Counts CPU wins that left a DMA request waiting.
   always_comb begin
      starve_d = starve_q;
      if (state_q == ST_IDLE) begin
         if (!DmaReq || dma_win) begin
            starve_d = '0;
         end else if (cpu_win) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign dma_force = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_win) begin
               state_d = ST_ACCESS;
               grant_d = GRANT_CPU;
               we_d    = CpuWE;
               addr_d  = CpuAddr;
               wdata_d = CpuWData;
            end else if (dma_win) begin
               state_d = ST_ACCESS;
               grant_d = GRANT_DMA;
               we_d    = DmaWE;
               addr_d  = DmaAddr;
               wdata_d = DmaWData;
            end
         end
         ST_ACCESS: begin
            if (tmr_tc) begin
               state_d = ST_DONE;
               if (!we_q && grant_q == GRANT_CPU) cpu_rdata_d = MemRData;
               if (!we_q && grant_q == GRANT_DMA) dma_rdata_d = MemRData;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            grant_d = GRANT_NONE;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = GRANT_NONE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q     <= ST_IDLE;
         grant_q     <= GRANT_NONE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign MemEn    = (state_q == ST_ACCESS);
   assign MemWE    = MemEn && tmr_tc && we_q;
   assign MemAddr  = addr_q;
   assign MemWData = wdata_q;
   assign CpuRData = cpu_rdata_q;
   assign DmaRData = dma_rdata_q;
   assign CpuReady = (state_q == ST_DONE) && (grant_q == GRANT_CPU);
   assign DmaReady = (state_q == ST_DONE) && (grant_q == GRANT_DMA);
   assign Grant    = grant_q;

endmodule
